serial_adder_ctrl: RTL

// - Bit-serial adder. Time-multiplexes one gate-level full_adder instance over

---
 rtl/serial_adder_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_adder_ctrl (with helper full_adder)                        |
// | Bit-serial adder: one full_adder reused over WIDTH cycles, LSB first.      |
// | Optional signed-overflow output enabled by SERIAL_ADDER_OVERFLOW_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_sum_bit;
  logic               w_cout;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [WIDTH-1:0]   w_sum_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum_bit),
    .o_cout (w_cout)
  );

  // A single-bit datapath has nothing to shift; the sum bit is the whole result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_shift   = 1'b0;
      assign w_b_shift   = 1'b0;
      assign w_sum_shift = w_sum_bit;
    end else begin : g_wn
      assign w_a_shift   = {1'b0, r_a[WIDTH-1:1]};
      assign w_b_shift   = {1'b0, r_b[WIDTH-1:1]};
      assign w_sum_shift = {w_sum_bit, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      o_s         <= '0;
      o_carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      o_overflow  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_carry_in;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= w_a_shift;
      r_b     <= w_b_shift;
      r_sum   <= w_sum_shift;
      r_carry <= w_cout;
      r_cnt   <= w_last ? '0 : r_cnt + c_cnt_w'(1);
      if (w_last) begin
        o_s         <= w_sum_shift;
        o_carry_out <= w_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        // r_carry here is the carry into the MSB position.
        o_overflow  <= r_carry ^ w_cout;
`endif
      end
    end
  end

endmodule
`default_nettype wire
